// File: rtl/cla_pkg.sv
// Shared constants and types for the carry-lookahead accumulator.
package cla_pkg;
  localparam int DATA_W = 16;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam logic [DATA_W-1:0] SAT_VAL = 16'hFFFF;
endpackage

// File: rtl/cla_16bit.sv
// 16-bit two-level carry-lookahead adder: four 4-bit lookahead groups
// whose carries-in come from a second lookahead level.
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);
  logic [15:0] g, p, cy;
  logic [3:0]  grp_g, grp_p;
  logic [4:0]  grp_c;

  assign g = a & b;
  assign p = a ^ b;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      localparam int B = 4 * gi;
      assign cy[B]   = grp_c[gi];
      assign cy[B+1] = g[B] | (p[B] & grp_c[gi]);
      assign cy[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & grp_c[gi]);
      assign cy[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                     | (p[B+2] & p[B+1] & p[B] & grp_c[gi]);
      assign grp_g[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                       | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign grp_p[gi] = &p[B+3:B];
    end
  endgenerate

  // Second lookahead level: group carries computed in parallel from cin.
  assign grp_c[0] = cin;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
  assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

  assign s    = p ^ cy;
  assign cout = grp_c[4];
endmodule

// File: rtl/cla_accumulator.sv
// Streaming packet accumulator around one cla_16bit; define SATURATE_EN to
// pin the sum at 16'hFFFF after any carry instead of wrapping.
module cla_accumulator
  import cla_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_last,
  input  logic               clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_sum,
  output logic               out_ovf,
  output logic [COUNT_W-1:0] out_count
);
  localparam logic [COUNT_W-1:0] CNT_ONE = 1;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t               state_q;
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 out_valid_q;
  logic [DATA_W-1:0]    out_sum_q;
  logic                 out_ovf_q;
  logic [COUNT_W-1:0]   out_count_q;

  logic [DATA_W-1:0]    add_a, add_s;
  logic                 add_cout;
  logic                 accept;
  logic                 ovf_base;
  logic [COUNT_W-1:0]   cnt_base;

  assign in_ready = (state_q == ACC);
  assign accept   = in_ready & in_valid;

  // A clear folded into an accept restarts the sum from this operand.
  assign add_a = clr ? '0 : acc_q;

  cla_16bit u_add (
    .a    (add_a),
    .b    (in_data),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_cout)
  );

  always_comb begin
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    count_d  = count_q;
    ovf_base = clr ? 1'b0 : ovf_q;
    cnt_base = clr ? '0 : count_q;
    if (accept) begin
`ifdef SATURATE_EN
      acc_d = (add_cout | ovf_base) ? SAT_VAL : add_s;
`else
      acc_d = add_s;
`endif
      ovf_d   = ovf_base | add_cout;
      count_d = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_ONE;
    end else if (in_ready && clr) begin
      acc_d   = '0;
      ovf_d   = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      case (state_q)
        ACC: begin
          acc_q   <= acc_d;
          ovf_q   <= ovf_d;
          count_q <= count_d;
          if (accept && in_last) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= acc_d;
            out_ovf_q   <= ovf_d;
            out_count_q <= count_d;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            state_q     <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign out_count = out_count_q;
endmodule

// File: tb/tb_cla_accumulator.sv
// Randomised and directed checks of cla_accumulator against a packet-level
// arithmetic model; two instances (COUNT_W=8 and COUNT_W=2) share stimulus.
module tb_cla_accumulator;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, clr, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_sum;
  logic [7:0]  out_count;
  logic        in_ready2, out_valid2, out_ovf2;
  logic [15:0] out_sum2;
  logic [1:0]  out_count2;

  int n_vec = 0;
  int n_err = 0;

  // Packet-level reference: true (unbounded) total and beat count.
  bit          m_done;
  longint      m_total;
  int          m_n;
  bit          r_valid;
  logic [15:0] r_sum;
  bit          r_ovf;
  int          r_n;

  always #5 clk = ~clk;

  cla_accumulator #(.COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .out_count(out_count)
  );

  cla_accumulator #(.COUNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .clr(clr),
    .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
    .out_ovf(out_ovf2), .out_count(out_count2)
  );

  function automatic logic [15:0] sum_of(input longint t);
    logic [15:0] w;
    w = t[15:0];
`ifdef SATURATE_EN
    if (t >= 65536) w = 16'hFFFF;
`endif
    return w;
  endfunction

  function automatic int cap(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic void model_reset();
    m_done = 0; m_total = 0; m_n = 0;
    r_valid = 0; r_sum = 0; r_ovf = 0; r_n = 0;
  endfunction

  // Drive one cycle (inputs set after a falling edge), advance the model,
  // and return at the following falling edge.
  task automatic step(input bit v, input logic [15:0] d, input bit l,
                      input bit c, input bit o);
    in_valid = v; in_data = d; in_last = l; clr = c; out_ready = o;
    if (!m_done) begin
      if (v) begin
        if (c) begin m_total = d; m_n = 1; end
        else   begin m_total += d; m_n++; end
        if (l) begin
          r_valid = 1; r_sum = sum_of(m_total);
          r_ovf = (m_total >= 65536); r_n = m_n; m_done = 1;
        end
      end else if (c) begin
        m_total = 0; m_n = 0;
      end
    end else if (o) begin
      m_done = 0; r_valid = 0; m_total = 0; m_n = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_data = 0; in_last = 0; clr = 0; out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || out_sum !== 16'h0 || out_ovf !== 1'b0 ||
        out_count !== 8'h0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset: valid=%b sum=%h ovf=%b cnt=%0d rdy=%b, required 0 0 0 0 1",
               out_valid, out_sum, out_ovf, out_count, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    step(1, 16'h0001, 0, 0, 1);
    step(1, 16'h0002, 0, 0, 1);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_early_valid: got %b required 0", out_valid);
    end
    step(1, 16'h0003, 1, 0, 1);
    n_vec++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0006 || out_ovf !== 1'b0 || out_count !== 8'd3) begin
      n_err++;
      $display("FAIL basic_result: valid=%b sum=%h ovf=%b cnt=%0d, required 1 0006 0 3",
               out_valid, out_sum, out_ovf, out_count);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL basic_done_ready: got %b required 0", in_ready);
    end
    step(0, 16'h0, 0, 0, 1);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL basic_handshake: valid=%b rdy=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] want;
`ifdef SATURATE_EN
    want = 16'hFFFF;
`else
    want = 16'h0010;
`endif
    step(1, 16'hFFF0, 0, 0, 1);
    step(1, 16'h0020, 1, 0, 1);
    n_vec++;
    if (out_valid !== 1'b1 || out_sum !== want || out_ovf !== 1'b1 || out_count !== 8'd2) begin
      n_err++;
      $display("FAIL overflow: valid=%b sum=%h ovf=%b cnt=%0d, required 1 %h 1 2",
               out_valid, out_sum, out_ovf, out_count, want);
    end
    step(0, 16'h0, 0, 0, 1);
  endtask

  task automatic test_hold();
    logic [15:0] s0;
    step(1, 16'h0040, 0, 0, 0);
    step(1, 16'h0004, 1, 0, 0);
    s0 = out_sum;
    n_vec++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0044) begin
      n_err++; $display("FAIL hold_entry: valid=%b sum=%h required 1 0044", out_valid, out_sum);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 16'($urandom), ($urandom_range(0, 1) == 1), 1'($urandom), 0);
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== s0 ||
          out_count !== 8'd2 || out_ovf !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle%0d: rdy=%b valid=%b sum=%h cnt=%0d ovf=%b, required 0 1 %h 2 0",
                 i, in_ready, out_valid, out_sum, out_count, out_ovf, s0);
      end
    end
    step(1, 16'h1111, 0, 0, 1);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL hold_release: valid=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    step(1, 16'h0009, 1, 0, 1);
    n_vec++;
    if (out_sum !== 16'h0009 || out_count !== 8'd1) begin
      n_err++; $display("FAIL hold_next: sum=%h cnt=%0d required 0009 1", out_sum, out_count);
    end
    step(0, 16'h0, 0, 0, 1);
  endtask

  task automatic test_clr();
    step(1, 16'h0100, 0, 0, 1);
    step(1, 16'h0200, 0, 0, 1);
    step(1, 16'h0005, 0, 1, 1);
    step(1, 16'h0001, 1, 0, 1);
    n_vec++;
    if (out_sum !== 16'h0006 || out_count !== 8'd2 || out_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL clr_accept: sum=%h cnt=%0d ovf=%b required 0006 2 0", out_sum, out_count, out_ovf);
    end
    step(0, 16'h0, 0, 0, 1);
    step(1, 16'hFFFF, 0, 0, 1);
    step(1, 16'h0002, 0, 0, 1);
    step(0, 16'h0, 0, 1, 1);
    step(1, 16'h0003, 1, 0, 1);
    n_vec++;
    if (out_sum !== 16'h0003 || out_count !== 8'd1 || out_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL clr_idle: sum=%h cnt=%0d ovf=%b required 0003 1 0", out_sum, out_count, out_ovf);
    end
    step(0, 16'h0, 0, 0, 1);
  endtask

  task automatic test_rst_mid();
    step(1, 16'h1234, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_sum !== 16'h0 || out_ovf !== 1'b0 ||
        out_count !== 8'h0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid: valid=%b sum=%h ovf=%b cnt=%0d rdy=%b, required 0 0 0 0 1",
               out_valid, out_sum, out_ovf, out_count, in_ready);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, 16'h0007, 1, 0, 1);
    n_vec++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0007 || out_count !== 8'd1) begin
      n_err++;
      $display("FAIL rst_next: valid=%b sum=%h cnt=%0d required 1 0007 1", out_valid, out_sum, out_count);
    end
    step(0, 16'h0, 0, 0, 1);
  endtask

  task automatic test_count_sat();
    for (int i = 0; i < 5; i++) step(1, 16'h0001, (i == 4), 0, 1);
    n_vec++;
    if (out_count2 !== 2'd3 || out_sum2 !== 16'h0005 || out_valid2 !== 1'b1) begin
      n_err++;
      $display("FAIL count_sat_w2: cnt=%0d sum=%h valid=%b required 3 0005 1", out_count2, out_sum2, out_valid2);
    end
    n_vec++;
    if (out_count !== 8'd5) begin
      n_err++; $display("FAIL count_w8: cnt=%0d required 5", out_count);
    end
    step(0, 16'h0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit v, l, c, o;
    logic [15:0] d;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 9) == 0);
      o = ($urandom_range(0, 4) < 3);
      d = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
      step(v, d, l, c, o);
      n_vec++;
      if (out_valid !== r_valid || in_ready !== !m_done || out_valid2 !== r_valid) begin
        n_err++;
        $display("FAIL rand%0d_ctrl: valid=%b rdy=%b valid2=%b required %b %b %b",
                 i, out_valid, in_ready, out_valid2, r_valid, !m_done, r_valid);
      end
      if (r_valid) begin
        n_vec++;
        if (out_sum !== r_sum || out_ovf !== r_ovf || out_count !== 8'(cap(r_n, 8)) ||
            out_sum2 !== r_sum || out_ovf2 !== r_ovf || out_count2 !== 2'(cap(r_n, 2))) begin
          n_err++;
          $display("FAIL rand%0d_result: sum=%h ovf=%b cnt=%0d cnt2=%0d required %h %b %0d %0d",
                   i, out_sum, out_ovf, out_count, out_count2, r_sum, r_ovf, cap(r_n, 8), cap(r_n, 2));
        end
      end
    end
    step(0, 16'h0, 0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_hold();
    test_clr();
    test_rst_mid();
    test_count_sat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cla_accumulator.md
# cla_accumulator

Streaming unsigned accumulator placed directly downstream of the 16-bit carry-lookahead adder. It accepts a packet of 16-bit operands over a valid/ready handshake and feeds each operand plus the running sum into one `cla_16bit` instance. It registers the adder's sum and carry-out, and presents the packet total with a sticky overflow flag and beat count over a second valid/ready handshake.

## Interface
Parameters:
- COUNT_W, default 8: width of the beat counter.

Ports:
- clk  input  1  rising-edge clock; the block uses one clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  an operand beat is present.
- in_ready  output  1  block can accept a beat.
- in_data  input  16  unsigned operand.
- in_last  input  1  this beat is the final beat of the packet.
- clr  input  1  synchronous clear of the partial sum; effective only in ACC.
- out_valid  output  1  result is available.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  16  packet total.
- out_ovf  output  1  sticky flag: an adder cout occurred during the packet (or saturation, see Configuration).
- out_count  output  COUNT_W  number of beats accepted in the packet, saturating.

## Operation
- State machine has two states: ACC and DONE.
- Reset values: state=ACC, acc=0, ovf=0, count=0, out_valid=0, out_sum=0, out_ovf=0, out_count=0.
- Adder connection: `cla_16bit` a=acc, b=in_data, cin=0; outputs s and cout.
- in_ready = (state==ACC). There is no combinational path from out_ready to in_ready.
- Accept, when state is ACC, in_valid=1 and clr=0:
  - acc <= s.
  - ovf <= ovf | cout.
  - count <= count+1, saturating at 2^COUNT_W-1.
- Accept with clr=1 in the same cycle:
  - acc <= in_data, computed with a=0.
  - ovf <= 0.
  - count <= 1.
- clr=1 with no accept, in ACC: acc, ovf and count all go to 0.
- Accept with in_last=1:
  - Performs the normal or cleared accept above.
  - Loads out_sum, out_ovf and out_count with the post-accept values.
  - Sets out_valid=1 and moves to DONE.
- DONE:
  - in_ready=0; in_valid and clr are ignored.
  - Outputs hold stable while out_ready=0.
  - On out_valid & out_ready: out_valid <= 0, acc/ovf/count <= 0, state returns to ACC.
- Arithmetic: unsigned and modulo 2^16 by default; carry beyond bit 15 is recorded only in ovf.
- A packet of one beat (in_last on the first beat) is legal.
- Reset mid-packet or during DONE: all state returns to reset values immediately, the partial packet is discarded, and no result is produced.

## Timing
- Throughput: one beat per cycle in ACC.
- Latency: a last beat accepted at edge N gives out_valid=1 after edge N, visible in cycle N+1.
- Minimum packet period is 2 cycles: one accept cycle plus one DONE cycle with out_ready=1. After the handshake edge, in_ready=1 in the next cycle.
- The adder path (acc -> `cla_16bit` -> acc) is the single-cycle critical path. No extra pipeline stage is permitted.
- out_* outputs are registered. in_ready is decoded from the state register only.

## Configuration
- SATURATE_EN defined:
  - Any accept with cout=1, or any accept while ovf=1, loads acc <= 16'hFFFF and sets ovf.
  - The sum stays pinned at 16'hFFFF until the packet completes, clr is applied, or reset occurs.
- SATURATE_EN undefined:
  - Wrap-around, acc <= s.
  - ovf remains a sticky carry indicator only.

## Structure
- Shared package cla_pkg holds:
  - the DATA_W=16 constant;
  - the state typedef with ACC and DONE;
  - the saturation constant 16'hFFFF.
- There is one sub-module: the existing `cla_16bit`, instantiated once. All other logic stays in cla_accumulator.

## Test plan
- Reset then packet 16'h0001, 16'h0002, 16'h0003 (last), out_ready=1 -> out_sum=16'h0006, out_ovf=0, out_count=3, out_valid exactly one cycle after the last accept.
- Packet 16'hFFF0, 16'h0020 (last) -> default build: out_sum=16'h0010, out_ovf=1. SATURATE_EN build: out_sum=16'hFFFF, out_ovf=1.
- Hold out_ready=0 for 5 cycles in DONE, driving in_valid=1 -> in_ready=0, outputs stable, no beats absorbed; release -> next packet starts from acc=0.
- clr together with the accept of 16'h0005, after prior beats 16'h0100 and 16'h0200, then 16'h0001 (last) -> out_sum=16'h0006, out_count=2.
- Assert rst mid-packet after 16'h1234 -> all outputs 0 and in_ready=1 after reset; next single-beat packet 16'h0007 (last) -> out_sum=16'h0007, out_count=1.
- With COUNT_W=2, send 5 beats of 16'h0001 -> out_count=3 (saturated), out_sum=16'h0005.
